add_seq: RTL

Multi-cycle wide adder sequencer: computes `{COUT,O} = I0 + I1 + CIN` for WIDTH-bit operands using one shared CHUNK-bit add-with-carry datapath (a ripple of full adders), processing one chunk per cycle LSB-first. The block holds the carry between chunks in a register. It sits between a valid/ready producer and consumer, so wide additions can be done on a small LUT/carry-chain footprint.

---
 rtl/add_seq.sv | 113 +++++++++++
 1 files changed

// File: rtl/add_seq.sv
// Multi-cycle wide adder: {COUT,O} = I0 + I1 + CIN, computed one CHUNK-bit slice per
// cycle, LSB first, through a single shared ripple-carry datapath.
module add_seq #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             I_VALID,
  output logic             I_READY,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic             CIN,
  output logic             O_VALID,
  input  logic             O_READY,
  output logic [WIDTH-1:0] O,
  output logic             COUT
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   a_reg, a_next;
  logic [WIDTH-1:0]   b_reg, b_next;
  logic [WIDTH-1:0]   res_reg, res_next;
  logic               carry_reg, carry_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               o_valid_reg;

  logic [CHUNK-1:0]   sum_chunk;
  logic [CHUNK:0]     ripple;

  // Shared chunk adder always works on the low slice of the shifting operand registers.
  assign ripple[0] = carry_reg;

  genvar gi;
  generate
    for (gi = 0; gi < CHUNK; gi++) begin : g_fa
      assign sum_chunk[gi]  = a_reg[gi] ^ b_reg[gi] ^ ripple[gi];
      assign ripple[gi + 1] = (a_reg[gi] & b_reg[gi]) | (ripple[gi] & (a_reg[gi] ^ b_reg[gi]));
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    res_next   = res_reg;
    carry_next = carry_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (I_VALID) begin
          a_next     = I0;
          b_next     = I1;
          carry_next = CIN;
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        a_next     = a_reg >> CHUNK;
        b_next     = b_reg >> CHUNK;
        carry_next = ripple[CHUNK];
        // Sum slices enter at the MSB end so slice 0 lands at the bottom after N shifts.
        res_next   = {sum_chunk, res_reg[WIDTH-1:CHUNK]};
        cnt_next   = cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_W'(N - 1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (O_READY) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_reg   <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      res_reg     <= '0;
      carry_reg   <= 1'b0;
      cnt_reg     <= '0;
      o_valid_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      res_reg     <= res_next;
      carry_reg   <= carry_next;
      cnt_reg     <= cnt_next;
      o_valid_reg <= (state_next == DONE);
    end
  end

  assign I_READY = (state_reg == IDLE);
  assign O_VALID = o_valid_reg;
  assign O       = res_reg;
  assign COUT    = carry_reg;

endmodule
